video_packet_source: RTL
========================

# video_packet_source

Transmit end of the video DMA stream interface. Accepts raw 24-bit RGB pixels from the camera front end and emits framed Avalon-ST packets to the system's `video_dma_sink` port. Packet framing uses `startofpacket` on the first pixel and `endofpacket` on the last pixel of a frame. A small show-ahead FIFO absorbs DMA backpressure. Overflowing or short frames are terminated cleanly and counted, so the sink never sees an unterminated packet.

## Interface
Parameters:
- `WIDTH`, 320, pixels per line; `WIDTH*HEIGHT` ≥ 2.
- `HEIGHT`, 240, lines per frame.
- `FIFO_DEPTH`, 16, entries; power of 2, ≥ 2.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cam_frame_start`  in  1  marks the current `cam_pixel_valid` beat as the first pixel of a frame.
- `cam_pixel_valid`  in  1  pixel present this cycle; no backpressure to the camera.
- `cam_pixel`  in  24  RGB888 pixel.
- `src_data`  out  24  stream data.
- `src_startofpacket`  out  1  first beat of a packet.
- `src_endofpacket`  out  1  last beat of a packet.
- `src_valid`  out  1  beat present.
- `src_ready`  in  1  sink accepts the beat.
- `frame_count`  out  16  complete frames written to the FIFO; wraps.
- `overflow_count`  out  16  frames lost or truncated by FIFO full; saturates at 0xFFFF.
- `short_count`  out  16  frames truncated by an early `cam_frame_start`; saturates.
- `busy`  out  1  state ≠ IDLE or FIFO not empty.

## Operation
FIFO:
- Entry width 26 bits: {eop, sop, data[23:0]}.
- Push allowed only when occupancy < `FIFO_DEPTH`. Occupancy is taken before the same-cycle pop; there is no full-FIFO pass-through.
- Pop when `src_valid && src_ready`.

FSM states:
- IDLE
  - `cam_pixel_valid && cam_frame_start && !full`: push {0,1,pixel}, pixel_cnt = 1, go to STREAM.
  - Same condition but FIFO full: `overflow_count` += 1, stay in IDLE.
  - Pixels without `cam_frame_start` are discarded.
- STREAM, on `cam_pixel_valid`:
  - `cam_frame_start` asserted: `short_count` += 1, discard pixel, go to CLOSE.
  - Else if full: `overflow_count` += 1, discard pixel, go to CLOSE.
  - Else if pixel_cnt == `WIDTH*HEIGHT`−1: push {1,0,pixel}, `frame_count` += 1, go to IDLE.
  - Else: push {0,0,pixel}, pixel_cnt += 1.
- CLOSE
  - All camera input is ignored, including `cam_frame_start`.
  - When not full: push filler {1,0,24'h000000}, go to IDLE.
  - The next frame must begin with a fresh `cam_frame_start` seen in IDLE.

Other rules:
- pixel_cnt width = clog2(`WIDTH*HEIGHT`).
- Counter rules: `frame_count` wraps; `overflow_count` and `short_count` saturate.
- Only one counter event is possible per cycle, because the FSM takes a single branch.

## Timing
- Reset: FIFO empty, state IDLE, pixel_cnt 0, all counters 0. All outputs are 0: `src_valid`, `src_startofpacket`, `src_endofpacket`, `src_data`, `busy`.
- Latency: a pixel pushed in cycle N is presented on `src_*` in cycle N+1 at the earliest. Outputs are registered, show-ahead.
- Handshake:
  - While `src_valid && !src_ready`, `src_data`, `src_startofpacket` and `src_endofpacket` are held stable.
  - `src_valid` never drops without an accepting beat.
- Throughput: one beat per cycle sustained when `src_ready` = 1.
- Pointer wrap: FIFO read and write pointers wrap modulo `FIFO_DEPTH`. Occupancy uses a pointer width of clog2(`FIFO_DEPTH`)+1.
- Every packet emitted begins with sop = 1 and ends with exactly one eop = 1 beat. A beat never carries both sop and eop.
- Reset asserted mid-frame clears everything immediately. Any partially sent packet is abandoned; the system resets the DMA on the same reset.

## Test plan
- Frame, WIDTH=4, HEIGHT=2, `src_ready`=1: frame_start + 8 consecutive pixels 0x000001..0x000008 -> 8 beats.
  - Beat 1 = 0x000001 with sop; beat 8 = 0x000008 with eop.
  - `frame_count`=1; `busy` returns to 0.
- Backpressure, FIFO_DEPTH=4, 8-pixel frame, `src_ready`=0 for 20 cycles then 1 -> `overflow_count`=1.
  - Output is 0x000001(sop), 0x000002, 0x000003, 0x000004, then filler 0x000000 with eop.
- Short frame: 5 pixels, then `cam_frame_start` on the 6th -> `short_count`=1.
  - Output is 5 pixel beats plus filler eop.
  - The second frame is skipped; a third frame_start produces a full 8-beat packet.
- Random `src_ready` (50%) over 3 frames, FIFO_DEPTH=16, pixels every 4th cycle -> 24 beats, data in order.
  - sop/eop exactly at frame boundaries; `frame_count`=3; no data change while stalled.
- `reset_n` low for 1 cycle after pixel 3 -> all outputs 0 and FIFO empty.
  - Pixels without `cam_frame_start` are ignored; the next full frame yields a correct 8-beat packet.
- IDLE with FIFO full (`src_ready`=0) plus frame_start -> `overflow_count` +1, nothing pushed, state stays IDLE.

Source files
------------

// File: rtl/video_packet_source.sv
// video_packet_source: frames camera pixels into Avalon-ST packets through a
// show-ahead FIFO. Frames that overflow or end early are closed with a filler eop beat.
module video_packet_source #(
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cam_frame_start,
    input  logic        cam_pixel_valid,
    input  logic [23:0] cam_pixel,
    output logic [23:0] src_data,
    output logic        src_startofpacket,
    output logic        src_endofpacket,
    output logic        src_valid,
    input  logic        src_ready,
    output logic [15:0] frame_count,
    output logic [15:0] overflow_count,
    output logic [15:0] short_count,
    output logic        busy
);

    localparam int unsigned PIXELS = WIDTH * HEIGHT;
    localparam int unsigned CNT_W  = $clog2(PIXELS);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(PIXELS - 1);
    localparam logic [PW-1:0]    DEPTH_P    = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        CLOSE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pixel_cnt;

    // FIFO entry: {eop, sop, data[23:0]}
    logic [25:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    occupancy;
    logic             full;
    logic             empty;
    logic             pop;
    logic [25:0]      head;

    // Occupancy is measured before any same-cycle pop, so a full FIFO never accepts a push.
    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy >= DEPTH_P);
    assign empty     = (occupancy == '0);
    assign pop       = !empty && src_ready;
    assign head      = mem[rd_ptr[AW-1:0]];

    // Show-ahead head of the FIFO drives the stream; idle beats read as zero.
    assign src_valid         = !empty;
    assign src_data          = empty ? '0 : head[23:0];
    assign src_startofpacket = !empty && head[24];
    assign src_endofpacket   = !empty && head[25];
    assign busy              = (state != IDLE) || !empty;

    // Framing FSM: owns the write side of the FIFO and the event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pixel_cnt      <= '0;
            wr_ptr         <= '0;
            frame_count    <= '0;
            overflow_count <= '0;
            short_count    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cam_pixel_valid && cam_frame_start) begin
                        if (!full) begin
                            mem[wr_ptr[AW-1:0]] <= {2'b01, cam_pixel};
                            wr_ptr              <= wr_ptr + PW'(1);
                            pixel_cnt           <= CNT_W'(1);
                            state               <= STREAM;
                        end else if (overflow_count != '1) begin
                            overflow_count <= overflow_count + 16'd1;
                        end
                    end
                end
                STREAM: begin
                    if (cam_pixel_valid) begin
                        if (cam_frame_start) begin
                            if (short_count != '1) begin
                                short_count <= short_count + 16'd1;
                            end
                            state <= CLOSE;
                        end else if (full) begin
                            if (overflow_count != '1) begin
                                overflow_count <= overflow_count + 16'd1;
                            end
                            state <= CLOSE;
                        end else if (pixel_cnt == LAST_PIXEL) begin
                            mem[wr_ptr[AW-1:0]] <= {2'b10, cam_pixel};
                            wr_ptr              <= wr_ptr + PW'(1);
                            frame_count         <= frame_count + 16'd1;
                            pixel_cnt           <= '0;
                            state               <= IDLE;
                        end else begin
                            mem[wr_ptr[AW-1:0]] <= {2'b00, cam_pixel};
                            wr_ptr              <= wr_ptr + PW'(1);
                            pixel_cnt           <= pixel_cnt + CNT_W'(1);
                        end
                    end
                end
                CLOSE: begin
                    if (!full) begin
                        mem[wr_ptr[AW-1:0]] <= {2'b10, 24'h000000};
                        wr_ptr              <= wr_ptr + PW'(1);
                        pixel_cnt           <= '0;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read pointer advances on each accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule
